sd_apb_fifo_ctrl: RTL
=====================

Name: sd_apb_fifo_ctrl

Overview:
Second-generation APB slave front end for the SD/SPI controller.
- Replaces direct buffer strobes with integrated parametrised store (write) and load (read) FIFOs.
- Adds programmable wait states, FIFO back-pressure via pready stalls, bounded-stall timeout with pslverr, and sticky overflow/underflow flags.
- Sits between the APB interconnect and the SPI/SD transfer engine.

Parameters:
DATA_W, 16, APB data width and FIFO word width (8..32)
ADDR_W, 3, APB address bits decoded (register offset = paddr[2:0])
FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2
WAIT_STATES, 0, extra access cycles inserted before any completion
STALL_MAX, 15, maximum blocked-FIFO stall cycles before an error completion

Ports:
pclk  in  1  clock
preset  in  1  reset; synchronous, active-high
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  ADDR_W  register offset
pwdata  in  DATA_W  write data
prdata  out  DATA_W  read data; valid only when pready=1, else 0
pready  out  1  transfer complete
pslverr  out  1  error completion; only asserted together with pready
st_data_o  out  DATA_W  store FIFO head (show-ahead)
st_valid_o  out  1  store FIFO not empty
st_ready_i  in  1  engine pops store FIFO when st_valid_o & st_ready_i
ld_data_i  in  DATA_W  engine read data
ld_valid_i  in  1  engine offers read data
ld_ready_o  out  1  load FIFO not full; push when ld_valid_i & ld_ready_o
addr_o  out  DATA_W  card address register
addr_ld_o  out  1  one-cycle pulse on ADDR write
ctrl_o  out  DATA_W  command register
ctrl_ld_o  out  1  one-cycle pulse on CTRL write
status_i  in  DATA_W  engine status

Behaviour:
Register map (paddr[2:0]):
- 0 W ST_DATA: push store FIFO.
- 1 R LD_DATA: pop load FIFO.
- 2 W ADDR.
- 3 W CTRL.
- 4 R STATUS = status_i.
- 5 R/W1C FSTAT:
  - [0] st_full, [1] st_empty, [2] ld_full, [3] ld_empty.
  - [4] st_ovf sticky, [5] ld_udf sticky.
  - Other bits read 0.
  - Writing 1 to bit 4 or 5 clears that bit.
- Any other offset, or wrong direction (write to 1/4, read from 0/2/3): pready=1, pslverr=1 on first eligible completion cycle; no side effects.

FSM:
- IDLE:
  - psel & !penable -> ACCESS; wait counter := WAIT_STATES; stall counter := 0.
- ACCESS:
  - Requires penable=1. If psel or penable drops, -> IDLE with no side effects (abort).
  - While wait counter != 0: decrement; pready=0.
  - When wait counter == 0:
    - Target not blocked: pready=1 and perform the side effect this cycle; -> IDLE.
    - Target blocked -> STALL.
    - Blocked means push to ST_DATA with st_full, or pop of LD_DATA with ld_empty.
- STALL:
  - Re-evaluate blocking each cycle.
  - Unblocked: complete normally (pready=1, side effect); -> IDLE.
  - Stall counter reaches STALL_MAX: pready=1, pslverr=1, no push/pop, set st_ovf or ld_udf; -> IDLE.
  - Otherwise increment stall counter.

Transfer timing and side effects:
- Zero-wait, unblocked transfer: setup cycle + one access cycle.
- Side effects (push, pop, register load, pulse, W1C) occur exactly once per transfer, in the pready=1 cycle only.
- addr_ld_o/ctrl_ld_o pulse in the cycle after the completion edge, aligned with the updated addr_o/ctrl_o.

FIFOs:
- Circular buffers with log2(FIFO_DEPTH)+1-bit pointers/counts.
- full = (count == FIFO_DEPTH); empty = (count == 0); flags taken from registered count.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, data ordering preserved.
- Push while full: not possible; refused by the blocking logic and ld_ready_o.
- Pop and push in the same cycle on the same FIFO never passes data through an empty FIFO.
- Pointers wrap modulo FIFO_DEPTH.

Reset (synchronous, dominates everything):
- FSM -> IDLE; all counters 0; both FIFOs empty; sticky flags 0.
- Outputs: prdata=0, pready=0, pslverr=0, addr_o=0, ctrl_o=0, addr_ld_o=0, ctrl_ld_o=0, st_valid_o=0.
- ld_ready_o=0 while preset=1, then 1.
- Reset mid-transfer abandons the transfer with no completion.

Test Plan:
- WAIT_STATES=0: write 0xA5A5 to offset 2 -> pready=1 on access cycle; addr_o=0xA5A5 with addr_ld_o pulsed once; pslverr=0.
- WAIT_STATES=2: read STATUS with status_i=0x1234 -> pready low for 2 access cycles, then pready=1 and prdata=0x1234.
- Fill store FIFO with 8 writes (0..7) with st_ready_i=0; 9th write stalls; raise st_ready_i after 5 cycles -> 9th write completes without pslverr; st_data_o pops in order 0..8.
- Read LD_DATA with load FIFO empty and STALL_MAX=15 -> pready+pslverr after 15 stall cycles; FSTAT[5]=1; write 0x0020 to offset 5 -> FSTAT[5]=0.
- Engine pushes 3 words 0x11,0x22,0x33 while APB pops concurrently -> reads return 0x11,0x22,0x33 in order; ld_empty set afterwards.
- Access offset 6, then assert preset mid-stall -> first gives pready+pslverr with no side effect; after reset all outputs at reset values and both FIFOs empty.

Source files
------------

// File: rtl/sd_apb_fifo_ctrl.sv
// APB slave front end for the SD/SPI engine: store/load FIFOs, wait states, stall timeout.
// pready is combinational from the access FSM; register updates and pulses land on the completion edge.
module sd_apb_fifo_ctrl_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
endmodule

module sd_apb_fifo_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_STATES = 0,
  parameter int STALL_MAX   = 15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] st_data_o,
  output logic              st_valid_o,
  input  logic              st_ready_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  output logic [DATA_W-1:0] addr_o,
  output logic              addr_ld_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              ctrl_ld_o,
  input  logic [DATA_W-1:0] status_i
);
  localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SCW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_STALL} state_t;

  state_t            r_state;
  logic [WCW-1:0]    r_wait;
  logic [SCW-1:0]    r_stall;
  logic              r_st_ovf, r_ld_udf;
  logic [DATA_W-1:0] r_addr, r_ctrl;
  logic              r_addr_ld, r_ctrl_ld;

  logic [2:0]        w_off;
  logic              w_legal, w_st_req, w_ld_req, w_blocked;
  logic              w_active, w_elig, w_timeout, w_done, w_err, w_ok;
  logic              w_st_full, w_st_empty, w_ld_full, w_ld_empty;
  logic              w_st_push, w_st_pop, w_ld_push, w_ld_pop;
  logic [DATA_W-1:0] w_ld_head, w_fstat;

  assign w_off    = paddr[2:0];
  assign w_st_req = pwrite && (w_off == 3'd0);
  assign w_ld_req = !pwrite && (w_off == 3'd1);

  always_comb begin
    w_legal = 1'b0;
    case (w_off)
      3'd0, 3'd2, 3'd3: w_legal = pwrite;
      3'd1, 3'd4:       w_legal = !pwrite;
      3'd5:             w_legal = 1'b1;
      default:          w_legal = 1'b0;
    endcase
  end

  // Only the FIFO data ports can block; every other target completes once wait states expire.
  assign w_blocked = (w_st_req && w_st_full) || (w_ld_req && w_ld_empty);
  assign w_active  = !preset && (r_state != S_IDLE) && psel && penable;
  assign w_elig    = w_active && (r_wait == '0);
  assign w_timeout = w_elig && w_blocked && (r_state == S_STALL) && (r_stall == SCW'(STALL_MAX));
  assign w_done    = w_elig && (!w_blocked || w_timeout);
  assign w_err     = w_done && (!w_legal || w_timeout);
  assign w_ok      = w_done && !w_err;

  assign w_st_push = w_ok && w_st_req;
  assign w_ld_pop  = w_ok && w_ld_req;
  assign w_st_pop  = st_valid_o && st_ready_i;
  assign w_ld_push = ld_valid_i && ld_ready_o;

  sd_apb_fifo_ctrl_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_st_fifo (
    .clk(pclk), .rst(preset), .i_push(w_st_push), .i_dat(pwdata), .i_pop(w_st_pop),
    .o_head(st_data_o), .o_full(w_st_full), .o_empty(w_st_empty)
  );

  sd_apb_fifo_ctrl_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .clk(pclk), .rst(preset), .i_push(w_ld_push), .i_dat(ld_data_i), .i_pop(w_ld_pop),
    .o_head(w_ld_head), .o_full(w_ld_full), .o_empty(w_ld_empty)
  );

  always_comb begin
    w_fstat      = '0;
    w_fstat[5:0] = {r_ld_udf, r_st_ovf, w_ld_empty, w_ld_full, w_st_empty, w_st_full};
  end

  always_comb begin
    prdata = '0;
    if (w_ok && !pwrite) begin
      case (w_off)
        3'd1:    prdata = w_ld_head;
        3'd4:    prdata = status_i;
        3'd5:    prdata = w_fstat;
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_stall   <= '0;
      r_st_ovf  <= 1'b0;
      r_ld_udf  <= 1'b0;
      r_addr    <= '0;
      r_ctrl    <= '0;
      r_addr_ld <= 1'b0;
      r_ctrl_ld <= 1'b0;
    end else begin
      r_addr_ld <= 1'b0;
      r_ctrl_ld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (psel && !penable) begin
            r_state <= S_ACCESS;
            r_wait  <= WCW'(WAIT_STATES);
            r_stall <= '0;
          end
        end
        S_ACCESS: begin
          if (!(psel && penable))  r_state <= S_IDLE;
          else if (r_wait != '0)   r_wait  <= r_wait - WCW'(1);
          else if (w_done)         r_state <= S_IDLE;
          else                     r_state <= S_STALL;
        end
        S_STALL: begin
          if (!(psel && penable) || w_done) r_state <= S_IDLE;
          else                              r_stall <= r_stall + SCW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_ok && pwrite) begin
        case (w_off)
          3'd2: begin r_addr <= pwdata; r_addr_ld <= 1'b1; end
          3'd3: begin r_ctrl <= pwdata; r_ctrl_ld <= 1'b1; end
          3'd5: begin
            if (pwdata[4]) r_st_ovf <= 1'b0;
            if (pwdata[5]) r_ld_udf <= 1'b0;
          end
          default: ;
        endcase
      end
      if (w_timeout) begin
        if (w_st_req) r_st_ovf <= 1'b1;
        else          r_ld_udf <= 1'b1;
      end
    end
  end

  assign pready     = w_done;
  assign pslverr    = w_err;
  assign st_valid_o = !w_st_empty;
  assign ld_ready_o = !preset && !w_ld_full;
  assign addr_o     = r_addr;
  assign addr_ld_o  = r_addr_ld;
  assign ctrl_o     = r_ctrl;
  assign ctrl_ld_o  = r_ctrl_ld;
endmodule
